// File: rtl/audio_pkg.sv
// Shared audio constants and encodings for the tone generator.
package audio_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int AMP_MAX        = 32767;
    localparam int SAMPLE_RATE_HZ = 44100;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SILENT = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/audio_tone_gen_if.sv
// Sample request / sample delivery bus between the tone generator and the I2S side.
interface audio_tone_gen_if
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
);
    logic                sample_req;
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] sample_out;

    // Tone generator side
    modport master (input sample_req, input out_ready, output out_valid, output sample_out);
    // Serializer side
    modport slave  (output sample_req, output out_ready, input out_valid, input sample_out);
endinterface

// File: rtl/audio_tone_gen_shaper.sv
// Combinational waveform shaper: phase top bits -> shaped, attenuated sample.
// Triangle is built only when AUDIO_TONE_GEN_TRI_EN is defined; otherwise it reads as silence.
module tone_wave_shaper
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
    input  logic [SAMPLE_W-1:0] i_top,
    input  logic [1:0]          i_wave_sel,
    input  logic [3:0]          i_volume,
    input  logic                i_enable,
    output logic [SAMPLE_W-1:0] o_sample
);
    localparam logic signed [SAMPLE_W-1:0] AMP = SAMPLE_W'(AMP_MAX);

    logic signed [SAMPLE_W-1:0] w_shaped;

`ifdef AUDIO_TONE_GEN_TRI_EN
    // Position inside the current quarter period, doubled to span 0..AMP
    logic [SAMPLE_W-1:0] w_ramp;
    assign w_ramp = {1'b0, i_top[SAMPLE_W-3:0], 1'b0};
`endif

    // Shape the waveform, then attenuate with a sign-preserving shift
    always_comb begin
        w_shaped = '0;
        if (i_enable) begin
            case (i_wave_sel)
                WAVE_SQUARE: w_shaped = i_top[SAMPLE_W-1] ? -AMP : AMP;
                WAVE_SAW:    w_shaped = i_top ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
`ifdef AUDIO_TONE_GEN_TRI_EN
                WAVE_TRI: begin
                    case (i_top[SAMPLE_W-1 -: 2])
                        2'd0:    w_shaped = w_ramp;
                        2'd1:    w_shaped = AMP - w_ramp;
                        2'd2:    w_shaped = -w_ramp;
                        default: w_shaped = w_ramp - AMP;
                    endcase
                end
`endif
                default:     w_shaped = '0;
            endcase
        end
        o_sample = w_shaped >>> i_volume;
    end
endmodule

// File: rtl/audio_tone_gen.sv
// Tone generator: phase accumulator advanced once per sample request, with a
// three-state request/compute/hold handshake and a sticky overrun flag.
// Optional triangle shaper: define AUDIO_TONE_GEN_TRI_EN.
module audio_tone_gen
    import audio_pkg::*;
#(
    parameter int PHASE_W  = 24,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PHASE_W-1:0] freq_inc,
    input  logic [1:0]         wave_sel,
    input  logic [3:0]         volume,
    audio_tone_gen_if.master   bus,
    output logic               overrun,
    input  logic               overrun_clr
);
    state_e              r_state, w_next;
    logic                w_accept, w_drop;
    logic [PHASE_W-1:0]  r_phase;
    logic                r_en;
    logic [1:0]          r_ws;
    logic [3:0]          r_vol;
    logic [SAMPLE_W-1:0] r_sample, w_sample;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state; a request is taken only in IDLE, anything else is a drop
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_drop   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.sample_req) begin
                    w_next   = ST_CALC;
                    w_accept = 1'b1;
                end
            end
            ST_CALC: begin
                w_drop = bus.sample_req;
                w_next = ST_HOLD;
            end
            ST_HOLD: begin
                w_drop = bus.sample_req;
                if (bus.out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Latch controls and advance the phase on each accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_en    <= 1'b0;
            r_ws    <= WAVE_SILENT;
            r_vol   <= '0;
        end else if (w_accept) begin
            r_en    <= enable;
            r_ws    <= wave_sel;
            r_vol   <= volume;
            r_phase <= enable ? r_phase + freq_inc : '0;
        end
    end

    tone_wave_shaper #(.SAMPLE_W(SAMPLE_W)) u_shaper (
        .i_top      (r_phase[PHASE_W-1 -: SAMPLE_W]),
        .i_wave_sel (r_ws),
        .i_volume   (r_vol),
        .i_enable   (r_en),
        .o_sample   (w_sample)
    );

    // Register the shaped sample in CALC; it then holds through HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_sample <= '0;
        else if (r_state == ST_CALC) r_sample <= w_sample;
    end

    // Sticky overrun: a drop wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              overrun <= 1'b0;
        else if (w_drop)      overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end

    assign bus.out_valid  = (r_state == ST_HOLD);
    assign bus.sample_out = r_sample;
endmodule

// File: tb/tb_audio_tone_gen.sv
// Self-checking bench for audio_tone_gen: cycle model + directed literal checks + random traffic.
`timescale 1ns/1ps
module tb_audio_tone_gen;
    import audio_pkg::*;
    localparam int PW = 24;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable, overrun, overrun_clr;
    logic [PW-1:0] freq_inc;
    logic [1:0]    wave_sel;
    logic [3:0]    volume;

    int checks = 0;
    int errors = 0;

    audio_tone_gen_if #(.SAMPLE_W(SW)) tone_if();

    audio_tone_gen #(.PHASE_W(PW), .SAMPLE_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .freq_inc    (freq_inc),
        .wave_sel    (wave_sel),
        .volume      (volume),
        .bus         (tone_if),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #83 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference sample value from the waveform definitions
    function automatic int shape(input int top, input int ws, input int vol, input bit en);
        int v, d, q, f;
        v = 0;
        if (en) begin
            case (ws)
                0: v = (top < 32768) ? 32767 : -32767;
                1: v = top - 32768;
`ifdef AUDIO_TONE_GEN_TRI_EN
                2: begin
                    q = top / 16384;
                    f = top % 16384;
                    if (q == 0)      v = 2 * f;
                    else if (q == 1) v = 32767 - 2 * f;
                    else if (q == 2) v = -2 * f;
                    else             v = 2 * f - 32767;
                end
`endif
                default: v = 0;
            endcase
        end
        d = 1 << vol;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    // Behavioural model: one sample in flight, shown two cycles after acceptance
    int m_phase  = 0;
    bit m_busy   = 0;
    int m_cyc    = 0;
    int m_pend   = 0;
    int m_sample = 0;
    bit m_ovr    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_busy = 0; m_cyc = 0; m_pend = 0; m_sample = 0; m_ovr = 0;
        end else begin
            bit drop;
            drop = tone_if.sample_req && m_busy;
            if (m_busy) begin
                if (m_cyc == 0) begin
                    m_cyc = 1;
                    m_sample = m_pend;
                end else if (tone_if.out_ready) begin
                    m_busy = 0;
                end
            end else if (tone_if.sample_req) begin
                m_phase = enable ? ((m_phase + int'(freq_inc)) & ((1 << PW) - 1)) : 0;
                m_pend  = shape(m_phase >> (PW - SW), int'(wave_sel), int'(volume), enable);
                m_busy  = 1;
                m_cyc   = 0;
            end
            if (drop) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
        end
    end

    // Compare DUT against the model every cycle
    always @(negedge clk) begin
        chk("out_valid", {31'b0, tone_if.out_valid}, {31'b0, (m_busy && m_cyc == 1)});
        chk("sample_out", {16'b0, tone_if.sample_out}, {16'b0, 16'(m_sample)});
        chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
        chk("phase", {8'b0, dut.r_phase}, {8'b0, m_phase[PW-1:0]});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; returns in the cycle the sample should be valid
    task automatic request(input bit en, input logic [1:0] ws, input logic [3:0] vol,
                           input logic [PW-1:0] inc);
        enable = en; wave_sel = ws; volume = vol; freq_inc = inc;
        tone_if.sample_req = 1'b1;
        cyc();
        tone_if.sample_req = 1'b0;
        cyc();
    endtask

    initial begin
        enable = 0; freq_inc = '0; wave_sel = 0; volume = 0;
        tone_if.sample_req = 0; tone_if.out_ready = 1; overrun_clr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", {31'b0, tone_if.out_valid}, 32'd0);
        chk("rst_sample", {16'b0, tone_if.sample_out}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);

        // 440 Hz square, latency
        enable = 1; wave_sel = 0; volume = 0; freq_inc = 24'd167392;
        tone_if.sample_req = 1'b1;
        cyc();
        tone_if.sample_req = 1'b0;
        chk("lat_n1_valid", {31'b0, tone_if.out_valid}, 32'd0);
        cyc();
        chk("lat_valid", {31'b0, tone_if.out_valid}, 32'd1);
        chk("lat_sample", {16'b0, tone_if.sample_out}, 32'h7FFF);
        chk("lat_phase", {8'b0, dut.r_phase}, 32'd167392);
        cyc();
        chk("lat_done", {31'b0, tone_if.out_valid}, 32'd0);

        // Phase wrap
        request(1, 2'd0, 4'd0, 24'hFFFFF0 - 24'd167392);
        chk("pre_wrap_phase", {8'b0, dut.r_phase}, 32'hFFFFF0);
        cyc();
        request(1, 2'd0, 4'd0, 24'h20);
        chk("wrap_phase", {8'b0, dut.r_phase}, 32'h10);
        chk("wrap_sample", {16'b0, tone_if.sample_out}, 32'h7FFF);
        cyc();

        // Volume and sign on saw at phase 0
        request(0, 2'd1, 4'd0, 24'h0);
        chk("dis_sample", {16'b0, tone_if.sample_out}, 32'h0);
        cyc();
        request(1, 2'd1, 4'd15, 24'h0);
        chk("vol15_sample", {16'b0, tone_if.sample_out}, 32'hFFFF);
        cyc();
        request(1, 2'd1, 4'd4, 24'h0);
        chk("vol4_sample", {16'b0, tone_if.sample_out}, 32'hF800);
        cyc();
        request(1, 2'd3, 4'd0, 24'h0);
        chk("silent_sample", {16'b0, tone_if.sample_out}, 32'h0);
        cyc();

        // Triangle build option
        request(1, 2'd2, 4'd0, 24'h400000);
`ifdef AUDIO_TONE_GEN_TRI_EN
        chk("tri_peak", {16'b0, tone_if.sample_out}, 32'h7FFF);
`else
        chk("tri_off", {16'b0, tone_if.sample_out}, 32'h0);
`endif
        cyc();
        request(1, 2'd2, 4'd0, 24'h800000);
`ifdef AUDIO_TONE_GEN_TRI_EN
        chk("tri_trough", {16'b0, tone_if.sample_out}, 32'h8001);
`else
        chk("tri_off2", {16'b0, tone_if.sample_out}, 32'h0);
`endif
        cyc();

        // Backpressure and overrun: phase 0xC00000 + 0x123456 = 0xD23456, saw = 0x5234
        tone_if.out_ready = 0;
        enable = 1; wave_sel = 2'd1; volume = 0; freq_inc = 24'h123456;
        tone_if.sample_req = 1; cyc(); tone_if.sample_req = 0;
        cyc(); cyc();
        tone_if.sample_req = 1; cyc(); tone_if.sample_req = 0;
        chk("bp_overrun", {31'b0, overrun}, 32'd1);
        chk("bp_valid", {31'b0, tone_if.out_valid}, 32'd1);
        chk("bp_sample", {16'b0, tone_if.sample_out}, 32'h5234);
        chk("bp_phase", {8'b0, dut.r_phase}, 32'hD23456);
        cyc(); cyc();
        chk("bp_hold", {16'b0, tone_if.sample_out}, 32'h5234);
        tone_if.out_ready = 1;
        cyc();
        chk("bp_xfer", {31'b0, tone_if.out_valid}, 32'd0);
        cyc();
        chk("bp_sticky", {31'b0, overrun}, 32'd1);
        overrun_clr = 1; cyc(); overrun_clr = 0;
        chk("bp_clr", {31'b0, overrun}, 32'd0);

        // Drop during the handshake cycle, coinciding with a clear
        tone_if.out_ready = 0;
        request(1, 2'd0, 4'd0, 24'h1000);
        tone_if.out_ready = 1; tone_if.sample_req = 1; overrun_clr = 1;
        cyc();
        tone_if.sample_req = 0; overrun_clr = 0;
        chk("hs_drop_ovr", {31'b0, overrun}, 32'd1);
        chk("hs_drop_valid", {31'b0, tone_if.out_valid}, 32'd0);
        cyc();
        chk("hs_drop_idle", {31'b0, tone_if.out_valid}, 32'd0);

        // Reset while in CALC, with overrun and a non-zero sample pending
        tone_if.sample_req = 1; cyc(); tone_if.sample_req = 0;
        #10 rst = 1'b1;
        #1;
        chk("rc_valid", {31'b0, tone_if.out_valid}, 32'd0);
        chk("rc_sample", {16'b0, tone_if.sample_out}, 32'd0);
        chk("rc_overrun", {31'b0, overrun}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        request(1, 2'd0, 4'd0, 24'h000777);
        chk("rc_phase", {8'b0, dut.r_phase}, 32'h777);
        cyc();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            enable             = ($urandom_range(0, 7) != 0);
            wave_sel           = 2'($urandom_range(0, 3));
            volume             = 4'($urandom_range(0, 15));
            freq_inc           = PW'($urandom);
            tone_if.sample_req = ($urandom_range(0, 2) == 0);
            tone_if.out_ready  = ($urandom_range(0, 2) != 0);
            overrun_clr        = ($urandom_range(0, 7) == 0);
            cyc();
        end
        tone_if.sample_req = 0; tone_if.out_ready = 1; overrun_clr = 0;
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
